// File: rtl/simon_seq_engine_pkg.sv
// Shared types and helpers for the Simon sequence engine: the FSM state encoding,
// the random-key fold and a counter width helper.
package simon_seq_engine_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      ADD          = 3'd1,
      PLAY_ON      = 3'd2,
      PLAY_OFF     = 3'd3,
      WAIT_PRESS   = 3'd4,
      WAIT_RELEASE = 3'd5,
      GAMEOVER     = 3'd6,
      WIN          = 3'd7
   } simonState_e;

   // Wide enough to hold any key index or NUM_KEYS itself (up to 16).
   localparam int FOLD_W = 5;

   // A counter that must reach n-1 never needs fewer than one bit.
   function automatic int cntWidth(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [FOLD_W-1:0] keyFold(input logic [FOLD_W-1:0] v,
                                                 input logic [FOLD_W-1:0] numKeys);
      logic [FOLD_W-1:0] folded;
      if (v >= numKeys) begin
         folded = v - numKeys;
      end else begin
         folded = v;
      end
      return folded;
   endfunction

endpackage

// File: rtl/simon_seq_engine_if.sv
// Game-side bus of the Simon engine: start, random source, player buttons and
// the lamp/status outputs back to the front end.
interface simon_seq_engine_if #(
   parameter int KEY_W = 2,
   parameter int LVL_W = 6
);
   logic             start;
   logic [KEY_W-1:0] rand_in;
   logic [KEY_W-1:0] player_key;
   logic             player_press;
   logic             simon_turn;
   logic [KEY_W-1:0] simon_key;
   logic             simon_press;
   logic [LVL_W-1:0] level;
   logic             game_over;
   logic             win;

   modport master (
      output start, rand_in, player_key, player_press,
      input  simon_turn, simon_key, simon_press, level, game_over, win
   );

   modport slave (
      input  start, rand_in, player_key, player_press,
      output simon_turn, simon_key, simon_press, level, game_over, win
   );
endinterface

// File: rtl/simon_seq_engine_mem.sv
// Key sequence store: synchronous write, asynchronous read, deliberately not reset
// so a restarted game simply overwrites old entries.
module simon_seq_mem #(
   parameter int DEPTH  = 32,
   parameter int KEY_W  = 2,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              writeEn,
   input  logic [ADDR_W-1:0] writeAddr,
   input  logic [KEY_W-1:0]  writeData,
   input  logic [ADDR_W-1:0] readAddr,
   output logic [KEY_W-1:0]  readData
);
   logic [KEY_W-1:0] mem_r [0:DEPTH-1];

   // Sequence entry write
   always_ff @(posedge clk) begin
      if (writeEn) begin
         mem_r[writeAddr] <= writeData;
      end
   end

   assign readData = mem_r[readAddr];
endmodule

// File: rtl/simon_seq_engine.sv
// Simon game engine: grows a random key sequence each round, plays it back on the
// lamps, then checks the player's presses with timeout, game-over and win detection.
module simon_seq_engine
   import simon_seq_engine_pkg::*;
#(
   parameter int NUM_KEYS      = 4,
   parameter int KEY_W         = $clog2(NUM_KEYS),
   parameter int MAX_LEN       = 32,
   parameter int ON_TICKS      = 30,
   parameter int OFF_TICKS     = 15,
   parameter int TIMEOUT_TICKS = 300,
   parameter int LVL_W         = $clog2(MAX_LEN + 1)
) (
   input  logic            clk,
   input  logic            reset,
   simon_seq_engine_if.slave bus
);
   localparam int ADDR_W = cntWidth(MAX_LEN);
   localparam int TICK_W = cntWidth((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
   localparam int TOUT_W = cntWidth(TIMEOUT_TICKS);

   simonState_e       state_r, state_s;
   logic [LVL_W-1:0]  len_r, len_s;
   logic [LVL_W-1:0]  idx_r, idx_s;
   logic [TICK_W-1:0] tick_r, tick_s;
   logic [TOUT_W-1:0] tout_r, tout_s;
   logic              pressQ_r;

   logic              pressEdge_s;
   logic              lastIdx_s;
   logic              keyMatch_s;
   logic              memWe_s;
   logic [KEY_W-1:0]  memWdata_s;
   logic [KEY_W-1:0]  memRdata_s;

   simon_seq_mem #(
      .DEPTH  (MAX_LEN),
      .KEY_W  (KEY_W),
      .ADDR_W (ADDR_W)
   ) seqMem (
      .clk       (clk),
      .writeEn   (memWe_s),
      .writeAddr (len_r[ADDR_W-1:0]),
      .writeData (memWdata_s),
      .readAddr  (idx_r[ADDR_W-1:0]),
      .readData  (memRdata_s)
   );

   // Raw random values beyond the key range wrap back into it.
   assign memWdata_s  = KEY_W'(keyFold(FOLD_W'(bus.rand_in), FOLD_W'(NUM_KEYS)));
   assign pressEdge_s = bus.player_press & ~pressQ_r;
   assign lastIdx_s   = (idx_r == (len_r - LVL_W'(1)));
   assign keyMatch_s  = (bus.player_key == memRdata_s);

   // State and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r  <= IDLE;
         len_r    <= '0;
         idx_r    <= '0;
         tick_r   <= '0;
         tout_r   <= '0;
         pressQ_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         len_r    <= len_s;
         idx_r    <= idx_s;
         tick_r   <= tick_s;
         tout_r   <= tout_s;
         pressQ_r <= bus.player_press;
      end
   end

   // Next-state and counter update logic
   always_comb begin
      state_s = state_r;
      len_s   = len_r;
      idx_s   = idx_r;
      tick_s  = tick_r;
      tout_s  = tout_r;
      memWe_s = 1'b0;
      case (state_r)
         IDLE, GAMEOVER, WIN: begin
            if (bus.start) begin
               state_s = ADD;
               len_s   = '0;
            end else begin
               state_s = state_r;
            end
         end
         ADD: begin
            memWe_s = 1'b1;
            len_s   = len_r + LVL_W'(1);
            idx_s   = '0;
            tick_s  = '0;
            state_s = PLAY_ON;
         end
         PLAY_ON: begin
            if (tick_r == TICK_W'(ON_TICKS - 1)) begin
               tick_s  = '0;
               state_s = PLAY_OFF;
            end else begin
               tick_s  = tick_r + TICK_W'(1);
            end
         end
         PLAY_OFF: begin
            if (tick_r == TICK_W'(OFF_TICKS - 1)) begin
               tick_s = '0;
               if (lastIdx_s) begin
                  idx_s   = '0;
                  tout_s  = '0;
                  state_s = WAIT_PRESS;
               end else begin
                  idx_s   = idx_r + LVL_W'(1);
                  state_s = PLAY_ON;
               end
            end else begin
               tick_s = tick_r + TICK_W'(1);
            end
         end
         WAIT_PRESS: begin
            tout_s = tout_r + TOUT_W'(1);
            // A press edge takes priority over an expiring timeout.
            if (pressEdge_s) begin
               if (keyMatch_s) begin
                  state_s = WAIT_RELEASE;
               end else begin
                  state_s = GAMEOVER;
               end
            end else if (tout_r == TOUT_W'(TIMEOUT_TICKS - 1)) begin
               state_s = GAMEOVER;
            end else begin
               state_s = WAIT_PRESS;
            end
         end
         WAIT_RELEASE: begin
            if (!bus.player_press) begin
               if (!lastIdx_s) begin
                  idx_s   = idx_r + LVL_W'(1);
                  tout_s  = '0;
                  state_s = WAIT_PRESS;
               end else if (len_r == LVL_W'(MAX_LEN)) begin
                  state_s = WIN;
               end else begin
                  state_s = ADD;
               end
            end else begin
               state_s = WAIT_RELEASE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign bus.simon_turn  = (state_r == ADD) || (state_r == PLAY_ON) || (state_r == PLAY_OFF);
   assign bus.simon_press = (state_r == PLAY_ON);
   assign bus.simon_key   = (state_r == PLAY_ON) ? memRdata_s : '0;
   assign bus.level       = len_r;
   assign bus.game_over   = (state_r == GAMEOVER);
   assign bus.win         = (state_r == WIN);
endmodule

// File: doc/simon_seq_engine.md
Name: simon_seq_engine

Overview:
- Parametrised Simon game engine: grows a random key sequence by one entry per round, plays it back, then checks the player's entries against it.
- Generalises key count, maximum sequence length, playback timing and player timeout. Adds explicit win and timeout detection.
- Sits between the 60 Hz game clock, the external random source, and the button/LED front end.

Parameters:
- NUM_KEYS, 4, number of player keys/lamps (2..16).
- KEY_W, $clog2(NUM_KEYS), key index width.
- MAX_LEN, 32, sequence length that ends the game with a win.
- ON_TICKS, 30, clk cycles a playback lamp is lit.
- OFF_TICKS, 15, clk cycles of dark gap after each playback lamp.
- TIMEOUT_TICKS, 300, clk cycles the player may idle in WAIT_PRESS.
- LVL_W, $clog2(MAX_LEN+1), level counter width.

Ports:
- clk  in  1  game clock (60 Hz)
- reset  in  1  asynchronous, active-high
- start  in  1  begin/restart game; honoured only in IDLE, GAMEOVER, WIN
- rand_in  in  KEY_W  free-running random value from the random block
- player_key  in  KEY_W  key index currently pressed
- player_press  in  1  debounced press level
- simon_turn  out  1  high in ADD, PLAY_ON, PLAY_OFF
- simon_key  out  KEY_W  key being played; valid while simon_press=1
- simon_press  out  1  playback lamp on
- level  out  LVL_W  current sequence length
- game_over  out  1  high in GAMEOVER
- win  out  1  high in WIN

Behaviour:
- Reset (async): state=IDLE, len=0, idx=0, counters=0, press_q=0. All outputs 0. Sequence memory is not cleared.
- Outputs are Moore-decoded from registered state. level=len.
- press_edge = player_press & ~press_q, with press_q registered every cycle. Only edges count, so a key held on entry to WAIT_PRESS is ignored until released.
- IDLE: start -> ADD, len=0.
- ADD (1 cycle):
  - mem[len] <= key_fold(rand_in), where key_fold(v) = v >= NUM_KEYS ? v - NUM_KEYS : v.
  - len <= len+1, idx <= 0, tick <= 0 -> PLAY_ON.
- PLAY_ON:
  - simon_press=1, simon_key=mem[idx].
  - tick counts 0..ON_TICKS-1; at ON_TICKS-1 -> PLAY_OFF, tick=0.
- PLAY_OFF:
  - Dark for OFF_TICKS cycles.
  - Then, if idx==len-1: idx=0, tout=0 -> WAIT_PRESS.
  - Otherwise idx++ -> PLAY_ON.
- Player input is ignored entirely in ADD/PLAY states.
- WAIT_PRESS:
  - tout increments each cycle.
  - press_edge with player_key==mem[idx] -> WAIT_RELEASE.
  - press_edge with mismatch -> GAMEOVER.
  - No edge and tout==TIMEOUT_TICKS-1 -> GAMEOVER.
  - If an edge and the timeout coincide, the edge wins.
- WAIT_RELEASE (no timeout), on player_press==0:
  - idx<len-1: idx++, tout=0 -> WAIT_PRESS.
  - idx==len-1 and len==MAX_LEN -> WIN.
  - Otherwise -> ADD.
- GAMEOVER / WIN: hold outputs and level. start -> ADD with len=0 (fresh game, level becomes 1).
- start in any other state is ignored.
- Latency: start sampled at edge t -> ADD after t -> PLAY_ON (simon_press=1, level=1) after edge t+1.
- Wrong press edge sampled at edge t -> game_over=1 after edge t.
- All counters saturate-free by construction. Widths are sized to their parameter max ($clog2 of ON/OFF/TIMEOUT).
- Reset mid-game: immediate IDLE regardless of state.

Decomposition:
- simon_pkg: state enum (IDLE, ADD, PLAY_ON, PLAY_OFF, WAIT_PRESS, WAIT_RELEASE, GAMEOVER, WIN), key_fold function, width helper constants.
- Sub-module simon_seq_mem: MAX_LEN x KEY_W, synchronous write, asynchronous read, no reset.
- Random source stays external, connected via rand_in.

Test Plan (NUM_KEYS=4, MAX_LEN=3, ON_TICKS=2, OFF_TICKS=1, TIMEOUT_TICKS=10 unless noted):
1. reset, start pulse, rand_in=2 -> simon_press=1 with simon_key=2 for exactly 2 cycles, beginning 2 edges after start; level=1; then 1 dark cycle, then simon_turn=0.
2. Continue: press key 2, release, rand_in=1 at ADD -> playback 2 then 1 (each 2 on + 1 off), level=2.
3. In WAIT_PRESS expecting 2, press key 3 -> game_over=1 one edge after the press edge; level stays 2. start -> level=1, new playback.
4. No press for 10 cycles in WAIT_PRESS -> game_over=1 exactly at the 10th cycle. An edge on that same cycle with the correct key -> WAIT_RELEASE instead.
5. Play 3 correct rounds -> win=1 after the final release, no ADD; start -> win=0, level=1.
6. NUM_KEYS=3, rand_in=3 at ADD -> simon_key=0. player_press held high across entry to WAIT_PRESS -> no check until release and re-press.
